// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
// Captures the decoded control word and operands from ID. It inserts a bubble
// when a branch flush arrives from EX, or when a load in EX feeds the
// instruction in ID.
// Optional feature: define ID_EX_PERF_EN to add saturating bubble/stall counters.
//
// Stall handshake: when stall_id is 1, this stage loads a bubble on the edge.
// The upstream IF/ID register and ID decoder must hold their instruction so
// that it is re-presented on the next cycle. A flush in the same cycle
// overrides the stall: stall_id drops to 0 and the wrong-path instruction is
// dropped instead of held.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    // ID control word
    input  logic        branch_id,
    input  logic        reg_write_id,
    input  logic        mem_read_id,
    input  logic        mem_write_id,
    input  logic        alu_src_id,
    input  logic        ext_op_id,
    input  logic [1:0]  reg_dst_id,
    input  logic [1:0]  mem_to_reg_id,
    input  logic [3:0]  alu_op_id,
    // ID operands and instruction fields
    input  logic [31:0] pc_plus4_id,
    input  logic [31:0] rs_data_id,
    input  logic [31:0] rt_data_id,
    input  logic [15:0] imm16_id,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic [4:0]  rd_id,
    input  logic [4:0]  shamt_id,
    input  logic [5:0]  funct_id,
    // Control from EX / to ID
    input  logic        flush_ex,
    output logic        stall_id,
    // Registered EX-side copies
    output logic        branch_ex,
    output logic        reg_write_ex,
    output logic        mem_read_ex,
    output logic        mem_write_ex,
    output logic        alu_src_ex,
    output logic        ext_op_ex,
    output logic [1:0]  reg_dst_ex,
    output logic [1:0]  mem_to_reg_ex,
    output logic [3:0]  alu_op_ex,
    output logic [31:0] pc_plus4_ex,
    output logic [31:0] rs_data_ex,
    output logic [31:0] rt_data_ex,
    output logic [31:0] imm32_ex,
    output logic [4:0]  rs_ex,
    output logic [4:0]  rt_ex,
    output logic [4:0]  rd_ex,
    output logic [4:0]  shamt_ex,
    output logic [5:0]  funct_ex,
    output logic        valid_ex
`ifdef ID_EX_PERF_EN
    ,
    output logic [15:0] bubble_cnt,
    output logic [15:0] stall_cnt
`endif
);

    logic [31:0] imm32_id;
    logic        hazard;
    logic        load_bubble;

    // Immediate extension happens in ID so EX sees a ready-to-use operand
    always_comb begin
        imm32_id = ext_op_id ? {{16{imm16_id[15]}}, imm16_id} : {16'h0000, imm16_id};
    end

    // Load-use detection from registered EX state only; the check ignores the
    // ID opcode and may stall on an instruction that does not read rt
    always_comb begin
        hazard      = mem_read_ex & valid_ex & (rt_ex != 5'd0) &
                      ((rt_ex == rs_id) | (rt_ex == rt_id));
        stall_id    = hazard & ~flush_ex;
        load_bubble = flush_ex | hazard;
    end

    // Pipeline register: a bubble is all-zero, so it never writes any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || load_bubble) begin
            branch_ex     <= 1'b0;
            reg_write_ex  <= 1'b0;
            mem_read_ex   <= 1'b0;
            mem_write_ex  <= 1'b0;
            alu_src_ex    <= 1'b0;
            ext_op_ex     <= 1'b0;
            reg_dst_ex    <= 2'b00;
            mem_to_reg_ex <= 2'b00;
            alu_op_ex     <= 4'h0;
            pc_plus4_ex   <= 32'h0;
            rs_data_ex    <= 32'h0;
            rt_data_ex    <= 32'h0;
            imm32_ex      <= 32'h0;
            rs_ex         <= 5'd0;
            rt_ex         <= 5'd0;
            rd_ex         <= 5'd0;
            shamt_ex      <= 5'd0;
            funct_ex      <= 6'd0;
            valid_ex      <= 1'b0;
        end else begin
            branch_ex     <= branch_id;
            reg_write_ex  <= reg_write_id;
            mem_read_ex   <= mem_read_id;
            mem_write_ex  <= mem_write_id;
            alu_src_ex    <= alu_src_id;
            ext_op_ex     <= ext_op_id;
            reg_dst_ex    <= reg_dst_id;
            mem_to_reg_ex <= mem_to_reg_id;
            alu_op_ex     <= alu_op_id;
            pc_plus4_ex   <= pc_plus4_id;
            rs_data_ex    <= rs_data_id;
            rt_data_ex    <= rt_data_id;
            imm32_ex      <= imm32_id;
            rs_ex         <= rs_id;
            rt_ex         <= rt_id;
            rd_ex         <= rd_id;
            shamt_ex      <= shamt_id;
            funct_ex      <= funct_id;
            valid_ex      <= 1'b1;
        end
    end

`ifdef ID_EX_PERF_EN
    // Saturating counters: every bubble, and only the load-use bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= 16'h0000;
            stall_cnt  <= 16'h0000;
        end else begin
            if (load_bubble && bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
            if (stall_id && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a
// transaction-level reference model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        branch, reg_write, mem_read, mem_write, alu_src, ext_op;
        logic [1:0]  reg_dst, mem_to_reg;
        logic [3:0]  alu_op;
        logic [31:0] pc_plus4, rs_data, rt_data;
        logic [15:0] imm16;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
    } id_t;

    typedef struct packed {
        logic        branch, reg_write, mem_read, mem_write, alu_src, ext_op;
        logic [1:0]  reg_dst, mem_to_reg;
        logic [3:0]  alu_op;
        logic [31:0] pc_plus4, rs_data, rt_data, imm32;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic        valid;
    } ex_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_t  id;
    logic flush_ex;
    logic stall_id;
    ex_t  dut_ex;
    ex_t  exp_ex;
    int   checks = 0;
    int   errors = 0;
    int   bub_m = 0;
    int   stl_m = 0;

    logic        branch_ex, reg_write_ex, mem_read_ex, mem_write_ex, alu_src_ex, ext_op_ex;
    logic [1:0]  reg_dst_ex, mem_to_reg_ex;
    logic [3:0]  alu_op_ex;
    logic [31:0] pc_plus4_ex, rs_data_ex, rt_data_ex, imm32_ex;
    logic [4:0]  rs_ex, rt_ex, rd_ex, shamt_ex;
    logic [5:0]  funct_ex;
    logic        valid_ex;
`ifdef ID_EX_PERF_EN
    logic [15:0] bubble_cnt, stall_cnt;
`endif

    assign dut_ex = {branch_ex, reg_write_ex, mem_read_ex, mem_write_ex, alu_src_ex, ext_op_ex,
                     reg_dst_ex, mem_to_reg_ex, alu_op_ex, pc_plus4_ex, rs_data_ex, rt_data_ex,
                     imm32_ex, rs_ex, rt_ex, rd_ex, shamt_ex, funct_ex, valid_ex};

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .branch_id(id.branch), .reg_write_id(id.reg_write), .mem_read_id(id.mem_read),
        .mem_write_id(id.mem_write), .alu_src_id(id.alu_src), .ext_op_id(id.ext_op),
        .reg_dst_id(id.reg_dst), .mem_to_reg_id(id.mem_to_reg), .alu_op_id(id.alu_op),
        .pc_plus4_id(id.pc_plus4), .rs_data_id(id.rs_data), .rt_data_id(id.rt_data),
        .imm16_id(id.imm16), .rs_id(id.rs), .rt_id(id.rt), .rd_id(id.rd),
        .shamt_id(id.shamt), .funct_id(id.funct),
        .flush_ex(flush_ex), .stall_id(stall_id),
        .branch_ex(branch_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
        .mem_write_ex(mem_write_ex), .alu_src_ex(alu_src_ex), .ext_op_ex(ext_op_ex),
        .reg_dst_ex(reg_dst_ex), .mem_to_reg_ex(mem_to_reg_ex), .alu_op_ex(alu_op_ex),
        .pc_plus4_ex(pc_plus4_ex), .rs_data_ex(rs_data_ex), .rt_data_ex(rt_data_ex),
        .imm32_ex(imm32_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
        .shamt_ex(shamt_ex), .funct_ex(funct_ex), .valid_ex(valid_ex)
`ifdef ID_EX_PERF_EN
        , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
`endif
    );

    // reference model: what EX should hold after capturing an ID instruction
    function automatic ex_t capture(input id_t d);
        ex_t e;
        e.branch     = d.branch;
        e.reg_write  = d.reg_write;
        e.mem_read   = d.mem_read;
        e.mem_write  = d.mem_write;
        e.alu_src    = d.alu_src;
        e.ext_op     = d.ext_op;
        e.reg_dst    = d.reg_dst;
        e.mem_to_reg = d.mem_to_reg;
        e.alu_op     = d.alu_op;
        e.pc_plus4   = d.pc_plus4;
        e.rs_data    = d.rs_data;
        e.rt_data    = d.rt_data;
        e.imm32      = d.ext_op ? 32'($signed(d.imm16)) : 32'(d.imm16);
        e.rs         = d.rs;
        e.rt         = d.rt;
        e.rd         = d.rd;
        e.shamt      = d.shamt;
        e.funct      = d.funct;
        e.valid      = 1'b1;
        return e;
    endfunction

    // a real load in EX whose non-zero destination is read by the ID instruction
    function automatic logic load_use(input ex_t e, input id_t d);
        return e.valid && e.mem_read && e.rt != 0 && (e.rt == d.rs || e.rt == d.rt);
    endfunction

    function automatic id_t rand_id();
        id_t r;
        logic [31:0] t;
        t = $urandom;
        r.branch = t[0]; r.reg_write = t[1]; r.mem_read = t[2]; r.mem_write = t[3];
        r.alu_src = t[4]; r.ext_op = t[5];
        r.reg_dst = 2'($urandom_range(0, 2));
        r.mem_to_reg = 2'($urandom_range(0, 2));
        r.alu_op = t[11:8];
        r.pc_plus4 = $urandom; r.rs_data = $urandom; r.rt_data = $urandom;
        r.imm16 = t[31:16];
        r.rs = 5'($urandom_range(0, 31)); r.rt = 5'($urandom_range(0, 31));
        r.rd = 5'($urandom_range(0, 31)); r.shamt = 5'($urandom_range(0, 31));
        r.funct = 6'($urandom_range(0, 63));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // one clock: check stall, advance the model, check the registered result
    task automatic step(input string tag);
        logic h;
        ex_t  nxt;
        #1;
        h = load_use(exp_ex, id);
        chk({tag, "_stall"}, 192'(stall_id), 192'(h & ~flush_ex));
        nxt = (flush_ex || h) ? '0 : capture(id);
        if ((flush_ex || h) && bub_m < 65535) bub_m++;
        if (h && !flush_ex && stl_m < 65535) stl_m++;
        @(posedge clk);
        #1;
        exp_ex = nxt;
        chk({tag, "_ex"}, 192'(dut_ex), 192'(exp_ex));
`ifdef ID_EX_PERF_EN
        chk({tag, "_bcnt"}, 192'(bubble_cnt), 192'(bub_m));
        chk({tag, "_scnt"}, 192'(stall_cnt), 192'(stl_m));
`endif
    endtask

    initial begin
        logic held;
        exp_ex   = '0;
        flush_ex = 1'b0;
        id       = rand_id();

        // reset state
        #12;
        chk("reset_ex", 192'(dut_ex), 192'(0));
        chk("reset_stall", 192'(stall_id), 192'(0));
        rst_n = 1'b1;

        // pass-through with sign extension, then zero extension
        id = rand_id(); id.mem_read = 1'b0;
        id.alu_op = 4'b0010; id.rd = 5'd5; id.imm16 = 16'h8000; id.ext_op = 1'b1;
        step("pass_sext");
        chk("pass_sext_imm", 192'(imm32_ex), 192'(32'hFFFF8000));
        chk("pass_sext_alu", 192'(alu_op_ex), 192'(4'b0010));
        chk("pass_sext_rd", 192'(rd_ex), 192'(5'd5));
        chk("pass_sext_valid", 192'(valid_ex), 192'(1'b1));
        id.ext_op = 1'b0;
        step("pass_zext");
        chk("pass_zext_imm", 192'(imm32_ex), 192'(32'h00008000));

        // load-use: lw rt=8, then consumer rs=8
        id = rand_id(); id.mem_read = 1'b1; id.reg_write = 1'b1; id.rt = 5'd8;
        step("lu_load");
        id = rand_id(); id.mem_read = 1'b0; id.reg_write = 1'b1; id.rs = 5'd8; id.rt = 5'd3;
        step("lu_bubble");
        chk("lu_bubble_valid", 192'(valid_ex), 192'(1'b0));
        chk("lu_bubble_rw", 192'(reg_write_ex), 192'(1'b0));
        step("lu_consume");
        chk("lu_consume_valid", 192'(valid_ex), 192'(1'b1));

        // no false stall: lw to $0, then non-load with matching rt
        id = rand_id(); id.mem_read = 1'b1; id.rt = 5'd0;
        step("nf_lw_r0");
        id = rand_id(); id.rs = 5'd0; id.rt = 5'd0;
        step("nf_r0_use");
        id = rand_id(); id.mem_read = 1'b0; id.rt = 5'd9;
        step("nf_nonload");
        id = rand_id(); id.rs = 5'd9;
        step("nf_nonload_use");

        // flush while hazard: flush wins, no stall, next instruction captured
        id = rand_id(); id.mem_read = 1'b1; id.rt = 5'd7;
        step("fh_load");
        id = rand_id(); id.rs = 5'd7; flush_ex = 1'b1;
        step("fh_flush");
        flush_ex = 1'b0;
        id = rand_id();
        step("fh_next");

        // back-to-back dependent loads each cost exactly one bubble
        id = rand_id(); id.mem_read = 1'b1; id.rt = 5'd5;
        step("bb_lw1");
        id = rand_id(); id.mem_read = 1'b1; id.rs = 5'd5; id.rt = 5'd6;
        step("bb_lw2_bubble");
        step("bb_lw2");
        id = rand_id(); id.mem_read = 1'b0; id.rs = 5'd6; id.rt = 5'd1;
        step("bb_use_bubble");
        step("bb_use");

        // reset asserted mid-stall clears everything without a clock edge
        id = rand_id(); id.mem_read = 1'b1; id.rt = 5'd4;
        step("rs_load");
        id = rand_id(); id.rs = 5'd4;
        #1;
        chk("rs_pre_stall", 192'(stall_id), 192'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("rs_async_ex", 192'(dut_ex), 192'(0));
        chk("rs_async_stall", 192'(stall_id), 192'(0));
        exp_ex = '0; bub_m = 0; stl_m = 0;
        #3;
        rst_n = 1'b1;
        id = rand_id();
        step("rs_first_capture");

        // randomized traffic: few registers so hazards are common; stalled
        // instructions are re-presented as the upstream stage would
        held = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                id = rand_id();
                id.rs = 5'($urandom_range(0, 3));
                id.rt = 5'($urandom_range(0, 3));
            end
            flush_ex = ($urandom_range(0, 7) == 0);
            held = load_use(exp_ex, id) && !flush_ex;
            step("rand");
        end
        flush_ex = 1'b0;

`ifdef ID_EX_PERF_EN
        // drive the bubble counter into saturation with flushes
        rst_n = 1'b0;
        #1;
        exp_ex = '0; bub_m = 0; stl_m = 0;
        rst_n = 1'b1;
        flush_ex = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        bub_m = 65534;
        chk("perf_preload", 192'(bubble_cnt), 192'(16'hFFFE));
        step("perf_sat1");
        step("perf_sat2");
        step("perf_sat3");
        chk("perf_saturated", 192'(bubble_cnt), 192'(16'hFFFF));
        chk("perf_stall_only", 192'(stall_cnt), 192'(0));
        flush_ex = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. Captures the decoded control word and operand data produced in ID and presents it registered to EX. Generates the `stall_id` signal consumed by the ID control decoder and the IF/ID register. Inserts bubbles on load-use stalls and on branch flushes.

## Interface
- No parameters (datapath fixed at 32 bits).
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `branch_id, reg_write_id, mem_read_id, mem_write_id, alu_src_id, ext_op_id` in 1 each: ID control bits.
- `reg_dst_id` in 2: 00=rt, 01=rd, 10=$31.
- `mem_to_reg_id` in 2: 00=ALU, 01=mem, 10=PC+4.
- `alu_op_id` in 4: ALU operation code.
- `pc_plus4_id` in 32: PC+4 of the ID instruction.
- `rs_data_id, rt_data_id` in 32 each: register-file read data.
- `imm16_id` in 16: instruction[15:0].
- `rs_id, rt_id, rd_id, shamt_id` in 5 each: instruction fields.
- `funct_id` in 6: instruction[5:0].
- `flush_ex` in 1: branch/jump resolved taken in EX; ID instruction is wrong-path.
- `stall_id` out 1: load-use stall; ID decoder and IF/ID hold.
- `*_ex` out: registered copies of every `*_id` input above, same widths. `imm16_id` is replaced by `imm32_ex` out 32 (extended immediate).
- `valid_ex` out 1: EX holds a real instruction (0 = bubble).

## Operation
- Extension: `imm32 = ext_op_id ? {{16{imm16_id[15]}}, imm16_id} : {16'h0, imm16_id}`, computed before the register.
- Load-use detect, combinational from registered state: `hazard = mem_read_ex & valid_ex & (rt_ex != 0) & ((rt_ex == rs_id) | (rt_ex == rt_id))`. The check is conservative and does not depend on ID opcode.
- `stall_id = hazard & ~flush_ex`.
- Next-state priority per clock edge:
  1. `flush_ex` = 1: load bubble.
  2. `hazard` = 1: load bubble. The ID instruction is held upstream and re-presented next cycle.
  3. Otherwise: load all `*_id` inputs, extended immediate, and `valid_ex` = 1.
- Bubble: every `*_ex` output and `valid_ex` = 0. A bubble therefore carries no RegWrite, MemRead, MemWrite or Branch.
- Flush with hazard in the same cycle: flush wins, `stall_id` = 0, and the wrong-path instruction is discarded rather than held.
- Stall persists at most one cycle per load. After the bubble, `mem_read_ex` = 0, so `hazard` clears.

## Timing
- Latency: 1 cycle from `*_id` to `*_ex`.
- `stall_id` is combinational in the same cycle from `*_ex` state, `rs_id`/`rt_id` and `flush_ex`. There is no path from `*_id` control inputs to `stall_id`.
- Reset (`rst_n` = 0, any time, including mid-stall): all outputs 0 immediately. This gives `valid_ex` = 0 and `stall_id` = 0. The first capture happens on the first rising edge after `rst_n` rises.
- Back-to-back loads with dependent consumers each produce exactly one bubble.

## Configuration
- `ID_EX_PERF_EN` defined:
  - Adds output `bubble_cnt` out 16, which increments on every edge that loads a bubble (flush or hazard).
  - Adds output `stall_cnt` out 16, which increments only on hazard bubbles.
  - Both counters saturate at 16'hFFFF and reset to 0 on `rst_n`.
- `ID_EX_PERF_EN` undefined: neither port nor counter exists, and the remaining behaviour is identical.

## Test plan
- Reset: drive `rst_n`=0 mid-run with `valid_ex`=1 -> all `*_ex`=0, `valid_ex`=0 and `stall_id`=0 before the next edge. After release, the first edge captures the ID inputs.
- Pass-through: `alu_op_id`=4'b0010, `rd_id`=5, `imm16_id`=16'h8000, `ext_op_id`=1 -> next cycle `alu_op_ex`=4'b0010, `rd_ex`=5, `imm32_ex`=32'hFFFF8000, `valid_ex`=1. Repeat with `ext_op_id`=0 -> `imm32_ex`=32'h00008000.
- Load-use: EX holds lw with `rt_ex`=8, ID `rs_id`=8 -> `stall_id`=1 and a bubble next cycle (`valid_ex`=0, `reg_write_ex`=0). The following cycle `stall_id`=0 and the consumer is captured.
- No false stall: `rt_ex`=0 with lw, `rs_id`=0 -> `stall_id`=0. A non-load in EX (`mem_read_ex`=0) with matching rt -> `stall_id`=0.
- Flush vs. hazard: `flush_ex`=1 while `hazard` is true -> `stall_id`=0, bubble loaded, and the next ID instruction is captured normally.
- With `ID_EX_PERF_EN`: preload the counter to 16'hFFFE via 65534 bubbles, then run 3 more bubbles -> `bubble_cnt` = 16'hFFFF (saturated). `stall_cnt` counts only hazard bubbles.
